// File: rtl/alu_arbiter_if.sv
// Request, ALU-control and response bundle shared by the arbiter and its environment.
// The slave modport is the arbiter's view. The master modport is the view of the requesters, the ALU and the consumer.
interface alu_arbiter_if;
  logic [1:0] ReqValid;
  logic [1:0] ReqReady;
  logic [1:0] ReqOp0;
  logic [1:0] ReqOp1;
  logic [7:0] ReqOperand0;
  logic [7:0] ReqOperand1;
  logic       ReqLast0;
  logic       ReqLast1;
  logic       AluWE;
  logic       AluSelSW;
  logic       AluSelImm;
  logic       AluUseMul;
  logic       AluUseACC;
  logic [7:0] AluImm;
  logic [7:0] AluRegData;
  logic [7:0] AluACC;
  logic       RespValid;
  logic       RespReady;
  logic [7:0] RespData;
  logic       RespTag;
  logic       RespTrunc;
  logic       Busy;

  modport slave (
    input  ReqValid, ReqOp0, ReqOp1, ReqOperand0, ReqOperand1, ReqLast0, ReqLast1,
    input  AluACC, RespReady,
    output ReqReady, AluWE, AluSelSW, AluSelImm, AluUseMul, AluUseACC, AluImm, AluRegData,
    output RespValid, RespData, RespTag, RespTrunc, Busy
  );

  modport master (
    output ReqValid, ReqOp0, ReqOp1, ReqOperand0, ReqOperand1, ReqLast0, ReqLast1,
    output AluACC, RespReady,
    input  ReqReady, AluWE, AluSelSW, AluSelImm, AluUseMul, AluUseACC, AluImm, AluRegData,
    input  RespValid, RespData, RespTag, RespTrunc, Busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin owner of the shared accumulator ALU, granted per multi-op transaction. ALU controls are driven in the accept cycle.
// Response follows 1 cycle after the final op and is held until RespReady. The non-owner is stalled with ReqReady low.
module alu_arbiter #(
  parameter int MAX_OPS = 8
) (
  input logic        Clock,
  input logic        nReset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_OPS);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULI = 2'b10;
  localparam logic [1:0] OP_LSW  = 2'b11;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;
  logic       trunc_q, trunc_d;
  logic [7:0] cnt_q, cnt_d;

  logic       own_vld;
  logic       own_last;
  logic [1:0] own_op;
  logic [7:0] own_operand;
  logic       winner;
  logic       accept;

  logic [1:0] ready_c;
  logic       we_c, sel_sw_c, use_mul_c, use_acc_c;
  logic [7:0] imm_c, reg_c;
  logic       resp_vld_c, resp_tag_c, resp_trunc_c, busy_c;
  logic [7:0] resp_dat_c;

  // Only the owner's request lines are ever selected, so the non-owner cannot reach the ALU.
  always_comb begin
    own_vld     = owner_q ? bus.ReqValid[1] : bus.ReqValid[0];
    own_last    = owner_q ? bus.ReqLast1    : bus.ReqLast0;
    own_op      = owner_q ? bus.ReqOp1      : bus.ReqOp0;
    own_operand = owner_q ? bus.ReqOperand1 : bus.ReqOperand0;
    winner      = (bus.ReqValid == 2'b11) ? ~last_gnt_q : bus.ReqValid[1];
    accept      = (state_q == BUSY) && own_vld;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    trunc_d    = trunc_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (|bus.ReqValid) begin
          owner_d    = winner;
          last_gnt_d = winner;
          trunc_d    = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (own_last || (cnt_d == MAX_CNT)) begin
            state_d = RESP;
            trunc_d = !own_last && (cnt_d == MAX_CNT);
          end
        end
      end
      RESP: begin
        if (bus.RespReady) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_c      = 2'b00;
    we_c         = 1'b0;
    sel_sw_c     = 1'b0;
    use_mul_c    = 1'b0;
    use_acc_c    = 1'b0;
    imm_c        = 8'd0;
    reg_c        = 8'd0;
    resp_vld_c   = 1'b0;
    resp_tag_c   = 1'b0;
    resp_trunc_c = 1'b0;
    resp_dat_c   = 8'd0;
    busy_c       = (state_q != IDLE);

    if (state_q == BUSY) begin
      ready_c = owner_q ? 2'b10 : 2'b01;
    end

    if (accept) begin
      we_c = 1'b1;
      case (own_op)
        OP_LOAD: reg_c = own_operand;
        OP_ADD: begin
          use_acc_c = 1'b1;
          reg_c     = own_operand;
        end
        OP_MULI: begin
          use_acc_c = 1'b1;
          use_mul_c = 1'b1;
          imm_c     = own_operand;
        end
        OP_LSW:  sel_sw_c = 1'b1;
        default: we_c = 1'b0;
      endcase
    end

    // ACC was written by the edge that closed the final op, and WE stays low here, so AluACC is stable.
    if (state_q == RESP) begin
      resp_vld_c   = 1'b1;
      resp_dat_c   = bus.AluACC;
      resp_tag_c   = owner_q;
      resp_trunc_c = trunc_q;
    end

    if (!nReset) begin
      ready_c      = 2'b00;
      we_c         = 1'b0;
      sel_sw_c     = 1'b0;
      use_mul_c    = 1'b0;
      use_acc_c    = 1'b0;
      imm_c        = 8'd0;
      reg_c        = 8'd0;
      resp_vld_c   = 1'b0;
      resp_tag_c   = 1'b0;
      resp_trunc_c = 1'b0;
      resp_dat_c   = 8'd0;
      busy_c       = 1'b0;
    end
  end

  assign bus.ReqReady   = ready_c;
  assign bus.AluWE      = we_c;
  assign bus.AluSelSW   = sel_sw_c;
  assign bus.AluSelImm  = 1'b0;
  assign bus.AluUseMul  = use_mul_c;
  assign bus.AluUseACC  = use_acc_c;
  assign bus.AluImm     = imm_c;
  assign bus.AluRegData = reg_c;
  assign bus.RespValid  = resp_vld_c;
  assign bus.RespData   = resp_dat_c;
  assign bus.RespTag    = resp_tag_c;
  assign bus.RespTrunc  = resp_trunc_c;
  assign bus.Busy       = busy_c;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      trunc_q    <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      trunc_q    <= trunc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two request drivers, an accumulator ALU model, and a per-requester result model.
// Monitor compares responses and handshake invariants.
module tb_alu_arbiter;
  localparam int MAXO = 4;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  always #5 Clock = ~Clock;

  alu_arbiter_if ifc ();
  alu_arbiter #(.MAX_OPS(MAXO)) dut (.Clock(Clock), .nReset(nReset), .bus(ifc));

  typedef struct { logic [1:0] op; logic [7:0] d; bit last; } op_t;
  typedef struct { logic [7:0] data; bit trunc; } exp_t;

  op_t  q0[$], q1[$], stg[$];
  exp_t eq0[$], eq1[$];
  int   tag_log[$];
  int   checks = 0, errors = 0;
  int   acc_n0 = 0, acc_n1 = 0, we_pulses = 0;
  int   m_cnt[2];
  logic [7:0] m_acc[2];
  logic [7:0] sw_val = 8'h00;
  logic [7:0] alu_acc = 8'h00;
  int   pr;
  bit   rr_hold = 1'b0, rr_rand = 1'b0;
  bit   v0 = 1'b0, v1 = 1'b0;

  assign ifc.ReqValid = {v1, v0};
  assign ifc.AluACC   = alu_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result of one op on the accumulator, straight from the op definitions.
  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    int p;
    case (op)
      2'd0: return d;
      2'd1: return a + d;
      2'd2: begin
        p = int'(signed'(a)) * int'(signed'(d));
        return p[10:3];
      end
      default: return sw_val;
    endcase
  endfunction

  task automatic add(input logic [1:0] op, input logic [7:0] d, input bit last);
    op_t o;
    o.op = op; o.d = d; o.last = last;
    stg.push_back(o);
  endtask

  // Splits the staged op stream into transactions (Last or op limit) and queues expected results.
  task automatic commit(input int r);
    exp_t e;
    foreach (stg[i]) begin
      m_acc[r] = ref_op(stg[i].op, m_acc[r], stg[i].d);
      m_cnt[r]++;
      if (stg[i].last || m_cnt[r] == MAXO) begin
        e.data  = m_acc[r];
        e.trunc = !stg[i].last && (m_cnt[r] == MAXO);
        if (r == 0) eq0.push_back(e); else eq1.push_back(e);
        m_cnt[r] = 0;
      end
      if (r == 0) q0.push_back(stg[i]); else q1.push_back(stg[i]);
    end
    stg.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || eq0.size() > 0 || eq1.size() > 0 || ifc.Busy) && n < budget) begin
      @(posedge Clock);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_done: timeout after %0d cycles, q0=%0d q1=%0d eq0=%0d eq1=%0d", n, q0.size(), q1.size(), eq0.size(), eq1.size());
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin : drv0
    bit took;
    forever begin
      @(negedge Clock);
      took = v0 && ifc.ReqReady[0];
      @(posedge Clock);
      #1;
      if (took) begin void'(q0.pop_front()); acc_n0++; end
      if (q0.size() > 0) begin
        v0 = 1'b1; ifc.ReqOp0 = q0[0].op; ifc.ReqOperand0 = q0[0].d; ifc.ReqLast0 = q0[0].last;
      end else begin
        v0 = 1'b0; ifc.ReqOp0 = 2'd0; ifc.ReqOperand0 = 8'd0; ifc.ReqLast0 = 1'b0;
      end
    end
  end

  initial begin : drv1
    bit took;
    forever begin
      @(negedge Clock);
      took = v1 && ifc.ReqReady[1];
      @(posedge Clock);
      #1;
      if (took) begin void'(q1.pop_front()); acc_n1++; end
      if (q1.size() > 0) begin
        v1 = 1'b1; ifc.ReqOp1 = q1[0].op; ifc.ReqOperand1 = q1[0].d; ifc.ReqLast1 = q1[0].last;
      end else begin
        v1 = 1'b0; ifc.ReqOp1 = 2'd0; ifc.ReqOperand1 = 8'd0; ifc.ReqLast1 = 1'b0;
      end
    end
  end

  initial begin : resp_drv
    ifc.RespReady = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      ifc.RespReady = rr_hold ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Accumulator ALU that the arbiter drives.
  always_comb pr = int'(signed'(alu_acc)) * int'(signed'(ifc.AluImm));
  always @(posedge Clock) begin
    if (ifc.AluWE) begin
      if (ifc.AluSelSW)       alu_acc <= sw_val;
      else if (ifc.AluUseMul) alu_acc <= pr[10:3];
      else if (ifc.AluUseACC) alu_acc <= alu_acc + ifc.AluRegData;
      else                    alu_acc <= ifc.AluRegData;
    end
  end

  initial begin : monitor
    logic [1:0]  acc_b;
    logic [1:0]  a_op;
    logic [7:0]  a_d;
    logic [19:0] e_alu;
    logic [63:0] all_out;
    logic [9:0]  snap;
    bit prev_last, prev_hold, prev_hs;
    exp_t e;
    prev_last = 0; prev_hold = 0; prev_hs = 0; snap = '0;
    forever begin
      @(negedge Clock);
      all_out = {29'd0, ifc.ReqReady, ifc.AluWE, ifc.AluSelSW, ifc.AluSelImm, ifc.AluUseMul, ifc.AluUseACC,
                 ifc.AluImm, ifc.AluRegData, ifc.RespValid, ifc.RespData, ifc.RespTag, ifc.RespTrunc, ifc.Busy};
      if (!nReset) begin
        chk("reset_outputs_zero", all_out, 64'd0);
        prev_last = 0; prev_hold = 0; prev_hs = 0;
      end else begin
        chk("ready_not_both", ifc.ReqReady == 2'b11, 0);
        acc_b = ifc.ReqValid & ifc.ReqReady;
        chk("we_iff_accept", ifc.AluWE, |acc_b);
        e_alu = 20'd0;
        if (|acc_b) begin
          a_op = acc_b[1] ? ifc.ReqOp1 : ifc.ReqOp0;
          a_d  = acc_b[1] ? ifc.ReqOperand1 : ifc.ReqOperand0;
          case (a_op)
            2'd0:    e_alu = {4'b0000, 8'd0, a_d};
            2'd1:    e_alu = {4'b0001, 8'd0, a_d};
            2'd2:    e_alu = {4'b0011, a_d, 8'd0};
            default: e_alu = {4'b1000, 16'd0};
          endcase
        end
        chk("alu_controls", {ifc.AluSelSW, ifc.AluSelImm, ifc.AluUseMul, ifc.AluUseACC, ifc.AluImm, ifc.AluRegData}, e_alu);
        if (!ifc.Busy) chk("idle_outputs_zero", all_out, 64'd0);
        if (ifc.RespValid) chk("resp_no_alu_no_ready", {ifc.ReqReady, ifc.AluWE}, 0);
        if (prev_last) chk("resp_latency", ifc.RespValid, 1);
        if (prev_hold) begin
          chk("resp_hold_valid", ifc.RespValid, 1);
          chk("resp_hold_fields", {ifc.RespData, ifc.RespTag, ifc.RespTrunc}, snap);
        end
        if (prev_hs) chk("idle_after_handshake", ifc.Busy, 0);
        if (ifc.AluWE) we_pulses++;
        if (ifc.RespValid && ifc.RespReady) begin
          tag_log.push_back(int'(ifc.RespTag));
          if ((ifc.RespTag ? eq1.size() : eq0.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: tag %0d data %0h with nothing expected", ifc.RespTag, ifc.RespData);
          end else begin
            e = ifc.RespTag ? eq1.pop_front() : eq0.pop_front();
            chk(ifc.RespTag ? "resp_data_req1" : "resp_data_req0", ifc.RespData, e.data);
            chk("resp_trunc", ifc.RespTrunc, e.trunc);
          end
        end
        prev_last = |(acc_b & {ifc.ReqLast1, ifc.ReqLast0});
        prev_hold = ifc.RespValid && !ifc.RespReady;
        prev_hs   = ifc.RespValid && ifc.RespReady;
        snap      = {ifc.RespData, ifc.RespTag, ifc.RespTrunc};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    int we0, n, len;
    logic [1:0] op;
    m_cnt[0] = 0; m_cnt[1] = 0; m_acc[0] = 8'd0; m_acc[1] = 8'd0;
    sw_val = 8'($urandom);

    // Tie from the first cycle out of reset: req0, then req1, then req0 again.
    add(2'd0, 8'd7, 1'b1); commit(0);
    add(2'd0, 8'd9, 1'b1); commit(1);
    repeat (3) @(posedge Clock);
    #1 nReset = 1'b1;
    wait_done(200);
    chk("tie_first_req0", tag_log.size() > 0 ? tag_log[0] : -1, 0);
    chk("tie_then_req1", tag_log.size() > 1 ? tag_log[1] : -1, 1);
    tag_log.delete();
    add(2'd0, 8'd11, 1'b1); commit(0);
    add(2'd0, 8'd12, 1'b1); commit(1);
    wait_done(200);
    chk("tie_repeat_req0", tag_log.size() > 0 ? tag_log[0] : -1, 0);

    // LOAD 5, ADD 3 -> 8 with exactly two ALU writes.
    we0 = we_pulses;
    add(2'd0, 8'd5, 1'b0); add(2'd1, 8'd3, 1'b1); commit(0);
    wait_done(200);
    chk("t1_we_pulses", we_pulses - we0, 2);

    // Req1 MULI and wraparound cases: 16, 5, 0x82.
    add(2'd0, 8'd16, 1'b0);  add(2'd2, 8'd8, 1'b1);
    add(2'd0, 8'd10, 1'b0);  add(2'd2, 8'd4, 1'b1);
    add(2'd0, 8'd120, 1'b0); add(2'd1, 8'd10, 1'b1);
    commit(1);
    wait_done(300);

    // Consumer stalls 3 cycles while req1 is pending.
    tag_log.delete();
    rr_hold = 1'b1;
    add(2'd0, 8'd33, 1'b1); commit(0);
    add(2'd0, 8'd44, 1'b1); commit(1);
    n = 0;
    while (!ifc.RespValid && n < 100) begin @(negedge Clock); n++; end
    chk("t4_resp_seen", ifc.RespValid, 1);
    repeat (3) @(posedge Clock);
    #1 rr_hold = 1'b0;
    wait_done(200);
    chk("t4_order", tag_log.size() > 1 ? {tag_log[0], tag_log[1]} : 64'hFFFF, {32'd0, 32'd1});

    // Op limit: LOAD 0 + 3 ADD truncates at 3; the 4th and 5th ADDs form the next transaction.
    add(2'd0, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) add(2'd1, 8'd1, k == 4);
    commit(1);
    wait_done(300);

    // Reset in the middle of a transaction: no response, idle, tie goes to req0.
    q0.push_back('{2'd0, 8'd1, 1'b0});
    q0.push_back('{2'd1, 8'd2, 1'b0});
    n = 0;
    while (q0.size() > 0 && n < 100) begin @(posedge Clock); n++; end
    repeat (2) @(negedge Clock);
    chk("t6_busy_before_reset", ifc.Busy, 1);
    @(posedge Clock); #1 nReset = 1'b0;
    @(posedge Clock); #1 nReset = 1'b1;
    @(negedge Clock);
    chk("t6_idle_after_reset", ifc.Busy, 0);
    tag_log.delete();
    add(2'd0, 8'd2, 1'b1); commit(0);
    add(2'd0, 8'd3, 1'b1); commit(1);
    wait_done(200);
    chk("t6_tie_req0", tag_log.size() > 0 ? tag_log[0] : -1, 0);

    // Random mixed traffic with random consumer backpressure.
    rr_rand = 1'b1;
    for (int t = 0; t < 120; t++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        op = (k == 0 || k == MAXO) ? (($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3) : 2'($urandom_range(0, 3));
        add(op, 8'($urandom), k == len - 1);
      end
      commit($urandom_range(0, 1));
    end
    wait_done(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
